uart_ext: RTL and testbench
===========================

Name: uart_ext

Overview:
- Parametrised successor to the fixed 8N1 UART: one module containing a transmitter and a receiver.
- Adds runtime baud divisor, configurable data width, parity and stop bits, an RX FIFO, and sticky error flags.
- Sits between the CPU I/O-port decode and the RS232 pins, replacing the fixed 115200-baud UART in new cores.

Parameters:
CLK, 24000000, system clock in Hz; used only to derive the default divisor.
BPS, 115200, default baud rate, selected when divisor==0.
DATA_BITS, 8, data bits per frame; legal range 5..8.
RXFIFO_DEPTH, 16, RX FIFO entries; power of two, >=4.
DIV_W, 16, divisor width.

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous reset, active low.
divisor  in  DIV_W  bit period in clk cycles minus 1; 0 selects CLK/BPS-1.
parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none.
stop2  in  1  1 = two stop bits on TX; RX always checks only the first stop bit.
txdata  in  DATA_BITS  byte to send.
txbegin  in  1  start request.
txbusy  out  1  transmitter busy.
rxdata  out  DATA_BITS  FIFO head, first-word-fall-through.
rxrecv  out  1  FIFO not empty.
data_read  in  1  pop FIFO head, one entry per cycle high.
rx_level  out  $clog2(RXFIFO_DEPTH)+1  FIFO occupancy.
err_parity  out  1  sticky parity error.
err_frame  out  1  sticky framing error.
err_overrun  out  1  sticky overrun.
err_clear  in  1  clears all three error flags.
rx  in  1  serial input.
tx  out  1  serial output.
rts  out  1  1 = stop sending.

Behaviour:
- Reset (async, rst_n=0) applies to all state, including mid-frame:
  - tx=1, txbusy=0, rxrecv=0, rx_level=0, all error flags 0, rts=0.
  - Synchroniser preset to 11, both FSMs in IDLE, FIFO emptied.
- Bit time: divisor+1 clocks (or CLK/BPS with divisor==0). The effective divisor is latched at TX accept and at RX start detect; later changes never affect a frame in flight.
- TX FSM (IDLE, START, DATA, PARITY, STOP1, STOP2):
  - Accept when txbegin=1 and txbusy=0: latch txdata, divisor, parity_mode and stop2; txbusy=1 from the next cycle.
  - Sequence: start bit 0, DATA_BITS bits LSB first, optional parity bit, 1 or 2 stop bits of 1.
  - txbusy falls in the cycle after the last stop bit completes.
  - txbegin while busy is ignored; a level-held txbegin does not retrigger until txbusy has dropped.
- RX FSM (IDLE, START, DATA, PARITY, STOP, RECOVER):
  - Input passes through a 2-FF synchroniser. A synchronised falling edge in IDLE enters START; the counter is preloaded to compensate the 2-cycle detect delay.
  - Every bit is sampled at mid-period (counter == half).
  - START sample not 0: glitch, return to IDLE, no error.
  - Parity mismatch: err_parity set, word discarded.
  - STOP sample 0: err_frame set, word discarded; enter RECOVER and wait for synchronised rx==1, then IDLE.
  - Valid stop: push the word the cycle after the mid-stop sample, then return to IDLE immediately (no wait for end of stop bit) to allow back-to-back frames.
- FIFO:
  - rxrecv and rxdata update the cycle after a push.
  - Pop when empty is ignored.
  - Push when full, with no pop in the same cycle: word dropped, err_overrun set, FIFO contents unchanged.
  - Push and pop in the same cycle: both are performed, level unchanged; this holds even when full, with no overrun.
  - Pointers wrap modulo RXFIFO_DEPTH; the level uses the extra MSB to distinguish full from empty.
- Error flags: set by events, cleared by err_clear; set wins over clear in the same cycle.

Optional Feature:
- UART_RTS_FLOW_EN defined: rts rises when rx_level >= RXFIFO_DEPTH-2 and falls when rx_level <= RXFIFO_DEPTH/2 (hysteresis); rts is registered.
- Not defined: rts is tied to 0.

Decomposition:
- Package uart_pkg holds:
  - TX and RX state enums.
  - Parity mode constants PAR_NONE, PAR_EVEN, PAR_ODD.
  - A function computing the default divisor from CLK and BPS.
- One sub-module, uart_rx_fifo: synchronous FWFT FIFO, parametrised by width and depth, exposing level, full and empty.
- TX and RX FSMs stay inline in uart_ext.

Test Plan:
- 8N1, divisor=207, send 0xA5 -> tx low 208 clk, then bits 1,0,1,0,0,1,0,1, then high 208 clk; txbusy high exactly 2080 clk.
- tx looped to rx, even parity, stop2=1, 0x3C then 0xC3 back-to-back -> FIFO holds 0x3C, 0xC3 in order, rx_level=2, no error flags set.
- Inject an odd-parity frame with a flipped parity bit, then a frame with stop=0 -> err_parity=1, err_frame=1, rx_level=0; pulse err_clear -> both flags 0.
- Send 17 bytes 0x00..0x10 with no reads, depth 16 -> rx_level=16, err_overrun=1; reads return 0x00..0x0F; with UART_RTS_FLOW_EN, rts=1 from level 14 and rts=0 once level is back to 8.
- Drive rx low for 50 clk at divisor=207 -> FSM returns to IDLE, FIFO and flags unchanged.
- Assert rst_n=0 mid-frame on both TX and RX -> tx=1 and txbusy=0 immediately; FIFO empty; a following clean frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the extended UART: FSM state encodings,
// parity mode codes, default divisor and parity computation.
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP1  = 3'd4,
        TX_STOP2  = 3'd5
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE    = 3'd0,
        RX_START   = 3'd1,
        RX_DATA    = 3'd2,
        RX_PARITY  = 3'd3,
        RX_STOP    = 3'd4,
        RX_RECOVER = 3'd5
    } rx_state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    function automatic int unsigned default_div(input int unsigned clk_hz, input int unsigned bps);
        return (clk_hz / bps) - 32'd1;
    endfunction

    // Narrower words are zero-extended by the caller; zeros do not change the XOR.
    function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] mode);
        logic p;
        if (mode == PAR_ODD) p = ~(^data);
        else                 p = ^data;
        return p;
    endfunction

    function automatic logic parity_en(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO for received words; pointers carry
// one extra MSB so a full FIFO is distinguishable from an empty one.
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);
    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;
    localparam logic [AW:0] PTR_ONE  = LVL_W'(1);
    localparam logic [AW:0] FULL_LVL = LVL_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign level     = r_wptr - r_rptr;
    assign full      = (level == FULL_LVL);
    assign empty     = (level == {LVL_W{1'b0}});
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign rdata     = r_mem[r_rptr[AW-1:0]];

    // Read and write pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= {LVL_W{1'b0}};
            r_rptr <= {LVL_W{1'b0}};
        end else begin
            if (w_do_push) r_wptr <= r_wptr + PTR_ONE;
            else           r_wptr <= r_wptr;
            if (w_do_pop)  r_rptr <= r_rptr + PTR_ONE;
            else           r_rptr <= r_rptr;
        end
    end

    // Storage array
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_ext.sv
// UART with runtime divisor, parity, 1/2 stop bits, RX FIFO and sticky errors.
// Define UART_RTS_FLOW_EN to drive rts from FIFO level with hysteresis.
module uart_ext
    import uart_pkg::*;
#(
    parameter int unsigned CLK          = 24000000,
    parameter int unsigned BPS          = 115200,
    parameter int          DATA_BITS    = 8,
    parameter int          RXFIFO_DEPTH = 16,
    parameter int          DIV_W        = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [DIV_W-1:0]                  divisor,
    input  logic [1:0]                        parity_mode,
    input  logic                              stop2,
    input  logic [DATA_BITS-1:0]              txdata,
    input  logic                              txbegin,
    output logic                              txbusy,
    output logic [DATA_BITS-1:0]              rxdata,
    output logic                              rxrecv,
    input  logic                              data_read,
    output logic [$clog2(RXFIFO_DEPTH):0]     rx_level,
    output logic                              err_parity,
    output logic                              err_frame,
    output logic                              err_overrun,
    input  logic                              err_clear,
    input  logic                              rx,
    output logic                              tx,
    output logic                              rts
);
    localparam int LVL_W = $clog2(RXFIFO_DEPTH) + 1;
    localparam logic [DIV_W-1:0] DEF_DIV    = DIV_W'(default_div(CLK, BPS));
    localparam logic [DIV_W-1:0] CNT_ONE    = DIV_W'(1);
    localparam logic [DIV_W-1:0] RX_PRELOAD = DIV_W'(2);
    localparam logic [2:0]       LAST_BIT   = 3'(DATA_BITS - 1);

    logic [DIV_W-1:0] w_div;
    assign w_div = (divisor == {DIV_W{1'b0}}) ? DEF_DIV : divisor;

    tx_state_t             r_tx_state;
    logic                  r_tx;
    logic                  r_txbusy;
    logic [DIV_W-1:0]      r_tx_cnt;
    logic [DIV_W-1:0]      r_tx_div;
    logic [2:0]            r_tx_bit;
    logic [DATA_BITS-1:0]  r_tx_shift;
    logic                  r_tx_pbit;
    logic                  r_tx_pen;
    logic                  r_tx_stop2;

    assign tx     = r_tx;
    assign txbusy = r_txbusy;

    // Transmit FSM; all frame settings are captured at accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_state <= TX_IDLE;
            r_tx       <= 1'b1;
            r_txbusy   <= 1'b0;
            r_tx_cnt   <= {DIV_W{1'b0}};
            r_tx_div   <= {DIV_W{1'b0}};
            r_tx_bit   <= 3'd0;
            r_tx_shift <= {DATA_BITS{1'b0}};
            r_tx_pbit  <= 1'b0;
            r_tx_pen   <= 1'b0;
            r_tx_stop2 <= 1'b0;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    if (txbegin && !r_txbusy) begin
                        r_tx_state <= TX_START;
                        r_tx       <= 1'b0;
                        r_txbusy   <= 1'b1;
                        r_tx_cnt   <= {DIV_W{1'b0}};
                        r_tx_div   <= w_div;
                        r_tx_shift <= txdata;
                        r_tx_pbit  <= parity_bit(8'(txdata), parity_mode);
                        r_tx_pen   <= parity_en(parity_mode);
                        r_tx_stop2 <= stop2;
                    end else begin
                        r_tx     <= 1'b1;
                        r_txbusy <= 1'b0;
                    end
                end
                default: begin
                    if (r_tx_cnt != r_tx_div) begin
                        r_tx_cnt <= r_tx_cnt + CNT_ONE;
                    end else begin
                        r_tx_cnt <= {DIV_W{1'b0}};
                        case (r_tx_state)
                            TX_START: begin
                                r_tx_state <= TX_DATA;
                                r_tx_bit   <= 3'd0;
                                r_tx       <= r_tx_shift[0];
                            end
                            TX_DATA: begin
                                if (r_tx_bit == LAST_BIT) begin
                                    r_tx_state <= r_tx_pen ? TX_PARITY : TX_STOP1;
                                    r_tx       <= r_tx_pen ? r_tx_pbit : 1'b1;
                                end else begin
                                    r_tx_bit   <= r_tx_bit + 3'd1;
                                    r_tx_shift <= r_tx_shift >> 1;
                                    r_tx       <= r_tx_shift[1];
                                end
                            end
                            TX_PARITY: begin
                                r_tx_state <= TX_STOP1;
                                r_tx       <= 1'b1;
                            end
                            TX_STOP1: begin
                                if (r_tx_stop2) begin
                                    r_tx_state <= TX_STOP2;
                                end else begin
                                    r_tx_state <= TX_IDLE;
                                    r_txbusy   <= 1'b0;
                                end
                            end
                            default: begin
                                r_tx_state <= TX_IDLE;
                                r_tx       <= 1'b1;
                                r_txbusy   <= 1'b0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    logic [1:0]            r_sync;
    logic                  w_rx_s;
    rx_state_t             r_rx_state;
    logic [DIV_W-1:0]      r_rx_cnt;
    logic [DIV_W-1:0]      r_rx_div;
    logic [2:0]            r_rx_bit;
    logic [DATA_BITS-1:0]  r_rx_shift;
    logic [1:0]            r_rx_mode;
    logic                  r_par_bad;
    logic                  r_push;
    logic                  r_ev_par;
    logic                  r_ev_frame;
    logic                  w_rx_mid;
    logic                  w_rx_end;

    assign w_rx_s   = r_sync[1];
    assign w_rx_mid = (r_rx_cnt == (r_rx_div >> 1));
    assign w_rx_end = (r_rx_cnt == r_rx_div);

    // Two-flop synchroniser on the serial input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sync <= 2'b11;
        else        r_sync <= {r_sync[0], rx};
    end

    // Receive FSM; returns to idle at mid-stop so back-to-back frames are caught
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= {DIV_W{1'b0}};
            r_rx_div   <= {DIV_W{1'b0}};
            r_rx_bit   <= 3'd0;
            r_rx_shift <= {DATA_BITS{1'b0}};
            r_rx_mode  <= PAR_NONE;
            r_par_bad  <= 1'b0;
            r_push     <= 1'b0;
            r_ev_par   <= 1'b0;
            r_ev_frame <= 1'b0;
        end else begin
            r_push     <= 1'b0;
            r_ev_par   <= 1'b0;
            r_ev_frame <= 1'b0;
            r_rx_cnt   <= w_rx_end ? {DIV_W{1'b0}} : r_rx_cnt + CNT_ONE;
            case (r_rx_state)
                RX_IDLE: begin
                    if (!w_rx_s) begin
                        r_rx_state <= RX_START;
                        r_rx_cnt   <= RX_PRELOAD;
                        r_rx_div   <= w_div;
                        r_rx_mode  <= parity_mode;
                        r_par_bad  <= 1'b0;
                    end
                end
                RX_START: begin
                    if (w_rx_mid && w_rx_s) begin
                        r_rx_state <= RX_IDLE;
                    end else if (w_rx_end) begin
                        r_rx_state <= RX_DATA;
                        r_rx_bit   <= 3'd0;
                    end
                end
                RX_DATA: begin
                    if (w_rx_mid) r_rx_shift <= {w_rx_s, r_rx_shift[DATA_BITS-1:1]};
                    if (w_rx_end) begin
                        if (r_rx_bit == LAST_BIT)
                            r_rx_state <= parity_en(r_rx_mode) ? RX_PARITY : RX_STOP;
                        else
                            r_rx_bit <= r_rx_bit + 3'd1;
                    end
                end
                RX_PARITY: begin
                    if (w_rx_mid && (w_rx_s != parity_bit(8'(r_rx_shift), r_rx_mode))) begin
                        r_ev_par  <= 1'b1;
                        r_par_bad <= 1'b1;
                    end
                    if (w_rx_end) r_rx_state <= RX_STOP;
                end
                RX_STOP: begin
                    if (w_rx_mid) begin
                        if (!w_rx_s) begin
                            r_ev_frame <= 1'b1;
                            r_rx_state <= RX_RECOVER;
                        end else begin
                            r_push     <= !r_par_bad;
                            r_rx_state <= RX_IDLE;
                        end
                    end
                end
                RX_RECOVER: begin
                    if (w_rx_s) r_rx_state <= RX_IDLE;
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    logic             w_full;
    logic             w_empty;
    logic [LVL_W-1:0] w_level;
    logic             w_overrun;

    uart_rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (RXFIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (r_push),
        .wdata (r_rx_shift),
        .pop   (data_read),
        .rdata (rxdata),
        .level (w_level),
        .full  (w_full),
        .empty (w_empty)
    );

    assign rx_level  = w_level;
    assign rxrecv    = !w_empty;
    // A full FIFO always has a head, so any pop makes room for the push.
    assign w_overrun = r_push && w_full && !data_read;

    logic r_err_par;
    logic r_err_frame;
    logic r_err_ovr;

    assign err_parity  = r_err_par;
    assign err_frame   = r_err_frame;
    assign err_overrun = r_err_ovr;

    // Sticky error flags; a new event beats a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_par   <= 1'b0;
            r_err_frame <= 1'b0;
            r_err_ovr   <= 1'b0;
        end else begin
            if (r_ev_par)        r_err_par <= 1'b1;
            else if (err_clear)  r_err_par <= 1'b0;
            else                 r_err_par <= r_err_par;
            if (r_ev_frame)      r_err_frame <= 1'b1;
            else if (err_clear)  r_err_frame <= 1'b0;
            else                 r_err_frame <= r_err_frame;
            if (w_overrun)       r_err_ovr <= 1'b1;
            else if (err_clear)  r_err_ovr <= 1'b0;
            else                 r_err_ovr <= r_err_ovr;
        end
    end

`ifdef UART_RTS_FLOW_EN
    localparam logic [LVL_W-1:0] RTS_ON  = LVL_W'(RXFIFO_DEPTH - 2);
    localparam logic [LVL_W-1:0] RTS_OFF = LVL_W'(RXFIFO_DEPTH / 2);
    logic r_rts;

    // Flow control with hysteresis between half and nearly full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  r_rts <= 1'b0;
        else if (w_level >= RTS_ON)  r_rts <= 1'b1;
        else if (w_level <= RTS_OFF) r_rts <= 1'b0;
        else                         r_rts <= r_rts;
    end

    assign rts = r_rts;
`else
    assign rts = 1'b0;
`endif

endmodule

// File: tb/tb_uart_ext.sv
// Directed self-checking bench for uart_ext (default parameters, 24 MHz / 115200).
module tb_uart_ext;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] divisor = 16'd207;
    logic [1:0]  parity_mode = 2'b00;
    logic        stop2 = 1'b0;
    logic [7:0]  txdata = 8'h00;
    logic        txbegin = 1'b0;
    logic        data_read = 1'b0;
    logic        err_clear = 1'b0;
    logic        rx_drv = 1'b1;
    logic        loop = 1'b0;
    logic        rx;
    logic        txbusy, rxrecv, err_parity, err_frame, err_overrun, tx, rts;
    logic [7:0]  rxdata;
    logic [4:0]  rx_level;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    assign rx = loop ? tx : rx_drv;

    uart_ext dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .divisor     (divisor),
        .parity_mode (parity_mode),
        .stop2       (stop2),
        .txdata      (txdata),
        .txbegin     (txbegin),
        .txbusy      (txbusy),
        .rxdata      (rxdata),
        .rxrecv      (rxrecv),
        .data_read   (data_read),
        .rx_level    (rx_level),
        .err_parity  (err_parity),
        .err_frame   (err_frame),
        .err_overrun (err_overrun),
        .err_clear   (err_clear),
        .rx          (rx),
        .tx          (tx),
        .rts         (rts)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic wait_busy(input logic val, input int limit, input string name);
        int n;
        n = 0;
        while (txbusy !== val && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (txbusy !== val) begin
            bad++;
            $display("FAIL %s: txbusy=%b expected %b within %0d cycles", name, txbusy, val, limit);
        end
    endtask

    task automatic send_tx(input logic [7:0] d);
        @(negedge clk);
        txdata  = d;
        txbegin = 1'b1;
        wait_busy(1'b1, 10, "tx_accept");
        txbegin = 1'b0;
        wait_busy(1'b0, 20000, "tx_done");
    endtask

    task automatic rx_frame(input logic [11:0] bits, input int nbits, input int bitclk);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            rx_drv = bits[i];
            repeat (bitclk - 1) @(negedge clk);
        end
        @(negedge clk);
        rx_drv = 1'b1;
        repeat (2 * bitclk) @(negedge clk);
    endtask

    task automatic pulse_clear();
        @(negedge clk); err_clear = 1'b1;
        @(negedge clk); err_clear = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] obs;
        obs = {tx, txbusy, rxrecv, rx_level, err_parity, err_frame, err_overrun, rts};
        total++;
        if (obs !== 12'b1000_0000_0000) begin
            bad++;
            $display("FAIL reset_in: got %b expected %b", obs, 12'b1000_0000_0000);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        obs = {tx, txbusy, rxrecv, rx_level, err_parity, err_frame, err_overrun, rts};
        total++;
        if (obs !== 12'b1000_0000_0000) begin
            bad++;
            $display("FAIL reset_out: got %b expected %b", obs, 12'b1000_0000_0000);
        end
    endtask

    task automatic test_tx_8n1();
        logic [9:0] expb;
        int c0;
        expb = {1'b1, 8'hA5, 1'b0};
        divisor = 16'd207; parity_mode = 2'b00; stop2 = 1'b0; loop = 1'b0;
        @(negedge clk); txdata = 8'hA5; txbegin = 1'b1;
        @(posedge clk); #1; txbegin = 1'b0; c0 = cyc;
        total++;
        if (tx !== 1'b0 || txbusy !== 1'b1) begin
            bad++; $display("FAIL tx_accept: tx=%b busy=%b expected 0 1", tx, txbusy);
        end
        repeat (207) @(posedge clk); #1;
        total++;
        if (tx !== 1'b0) begin bad++; $display("FAIL tx_start_len: tx=%b at clk 207 expected 0", tx); end
        for (int i = 1; i < 10; i++) begin
            repeat ((i == 1) ? 1 : 208) @(posedge clk); #1;
            total++;
            if (tx !== expb[i]) begin
                bad++; $display("FAIL tx_bit%0d: tx=%b expected %b", i, tx, expb[i]);
            end
        end
        wait_busy(1'b0, 400, "tx_end");
        total++;
        if (cyc - c0 != 2080) begin
            bad++; $display("FAIL tx_busy_len: %0d clk expected 2080", cyc - c0);
        end
    endtask

    task automatic test_back_to_back();
        loop = 1'b1; parity_mode = 2'b01; stop2 = 1'b1;
        @(negedge clk); txdata = 8'h3C; txbegin = 1'b1;
        wait_busy(1'b1, 10, "b2b_first");
        txdata = 8'hC3;
        wait_busy(1'b0, 20000, "b2b_gap");
        wait_busy(1'b1, 10, "b2b_second");
        txbegin = 1'b0;
        wait_busy(1'b0, 20000, "b2b_done");
        repeat (20) @(negedge clk);
        total++;
        if (rx_level !== 5'd2 || rxdata !== 8'h3C || {err_parity, err_frame, err_overrun} !== 3'b000) begin
            bad++; $display("FAIL b2b_first: level=%0d data=%h errs=%b expected 2 3c 000",
                            rx_level, rxdata, {err_parity, err_frame, err_overrun});
        end
        data_read = 1'b1; @(negedge clk); data_read = 1'b0;
        total++;
        if (rx_level !== 5'd1 || rxdata !== 8'hC3) begin
            bad++; $display("FAIL b2b_second: level=%0d data=%h expected 1 c3", rx_level, rxdata);
        end
        data_read = 1'b1; @(negedge clk); data_read = 1'b0;
        total++;
        if (rx_level !== 5'd0 || rxrecv !== 1'b0) begin
            bad++; $display("FAIL b2b_drain: level=%0d recv=%b expected 0 0", rx_level, rxrecv);
        end
    endtask

    task automatic test_errors();
        loop = 1'b0; parity_mode = 2'b10; stop2 = 1'b0; divisor = 16'd207;
        rx_frame({1'b1, 1'b1, 1'b0, 8'h55, 1'b0}, 12, 208);
        total++;
        if ({err_parity, err_frame, err_overrun} !== 3'b100 || rx_level !== 5'd0) begin
            bad++; $display("FAIL err_parity: errs=%b level=%0d expected 100 0",
                            {err_parity, err_frame, err_overrun}, rx_level);
        end
        rx_frame({1'b1, 1'b0, 1'b1, 8'h0F, 1'b0}, 12, 208);
        total++;
        if ({err_parity, err_frame, err_overrun} !== 3'b110 || rx_level !== 5'd0) begin
            bad++; $display("FAIL err_frame: errs=%b level=%0d expected 110 0",
                            {err_parity, err_frame, err_overrun}, rx_level);
        end
        pulse_clear();
        total++;
        if ({err_parity, err_frame, err_overrun} !== 3'b000) begin
            bad++; $display("FAIL err_clear: errs=%b expected 000", {err_parity, err_frame, err_overrun});
        end
    endtask

    task automatic test_overrun();
        int  lvl;
        logic exp_rts;
        loop = 1'b1; parity_mode = 2'b00; stop2 = 1'b0; divisor = 16'd15;
        for (int i = 0; i < 17; i++) begin
            send_tx(8'(i));
            repeat (4) @(negedge clk);
            lvl = (i < 16) ? i + 1 : 16;
`ifdef UART_RTS_FLOW_EN
            exp_rts = (lvl >= 14);
`else
            exp_rts = 1'b0;
`endif
            total++;
            if (rx_level !== 5'(lvl) || rts !== exp_rts || err_overrun !== (i == 16)) begin
                bad++; $display("FAIL fill%0d: level=%0d rts=%b ovr=%b expected %0d %b %b",
                                i, rx_level, rts, err_overrun, lvl, exp_rts, (i == 16));
            end
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            total++;
            if (rxdata !== 8'(i)) begin
                bad++; $display("FAIL read%0d: data=%h expected %h", i, rxdata, 8'(i));
            end
            data_read = 1'b1;
            @(negedge clk); data_read = 1'b0;
            @(negedge clk);
            lvl = 15 - i;
`ifdef UART_RTS_FLOW_EN
            exp_rts = (lvl > 8);
`else
            exp_rts = 1'b0;
`endif
            total++;
            if (rx_level !== 5'(lvl) || rts !== exp_rts) begin
                bad++; $display("FAIL drain%0d: level=%0d rts=%b expected %0d %b", i, rx_level, rts, lvl, exp_rts);
            end
        end
        data_read = 1'b1; @(negedge clk); data_read = 1'b0; @(negedge clk);
        total++;
        if (rx_level !== 5'd0 || rxrecv !== 1'b0) begin
            bad++; $display("FAIL pop_empty: level=%0d recv=%b expected 0 0", rx_level, rxrecv);
        end
    endtask

    task automatic test_glitch();
        pulse_clear();
        loop = 1'b0; divisor = 16'd207; parity_mode = 2'b00;
        @(negedge clk); rx_drv = 1'b0;
        repeat (50) @(negedge clk);
        rx_drv = 1'b1;
        repeat (400) @(negedge clk);
        total++;
        if (rx_level !== 5'd0 || {err_parity, err_frame, err_overrun} !== 3'b000) begin
            bad++; $display("FAIL glitch: level=%0d errs=%b expected 0 000",
                            rx_level, {err_parity, err_frame, err_overrun});
        end
        rx_frame({1'b1, 1'b1, 1'b1, 8'h81, 1'b0}, 12, 208);
        total++;
        if (rx_level !== 5'd1 || rxdata !== 8'h81) begin
            bad++; $display("FAIL glitch_after: level=%0d data=%h expected 1 81", rx_level, rxdata);
        end
    endtask

    task automatic test_reset_midframe();
        loop = 1'b1;
        @(negedge clk); txdata = 8'h00; txbegin = 1'b1;
        wait_busy(1'b1, 10, "mid_accept");
        txbegin = 1'b0;
        repeat (700) @(negedge clk);
        rst_n = 1'b0; #1;
        total++;
        if (tx !== 1'b1 || txbusy !== 1'b0 || rx_level !== 5'd0 || rxrecv !== 1'b0) begin
            bad++; $display("FAIL mid_reset: tx=%b busy=%b level=%0d recv=%b expected 1 0 0 0",
                            tx, txbusy, rx_level, rxrecv);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_tx(8'h5A);
        repeat (20) @(negedge clk);
        total++;
        if (rx_level !== 5'd1 || rxdata !== 8'h5A || {err_parity, err_frame, err_overrun} !== 3'b000) begin
            bad++; $display("FAIL post_reset: level=%0d data=%h errs=%b expected 1 5a 000",
                            rx_level, rxdata, {err_parity, err_frame, err_overrun});
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        test_tx_8n1();
        test_back_to_back();
        test_errors();
        test_overrun();
        test_glitch();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
